// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm trigger block.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam int unsigned RING_SECONDS_DEFAULT   = 60;
  localparam int unsigned SNOOZE_SECONDS_DEFAULT = 300;
  localparam int unsigned MAX_SNOOZE_DEFAULT     = 3;

endpackage

// File: rtl/alarm_time_match.sv
// Digit-for-digit BCD comparison of the current time against the alarm
// setting, true only on the first second (ss == 00) of the alarm minute.
// No range checking: an invalid digit on either side simply fails to match.
module alarm_time_match (
  input  logic [3:0] hr_high,
  input  logic [3:0] hr_low,
  input  logic [3:0] min_high,
  input  logic [3:0] min_low,
  input  logic [3:0] sec_high,
  input  logic [3:0] sec_low,
  input  logic [3:0] hr_high_setting,
  input  logic [3:0] hr_low_setting,
  input  logic [3:0] min_high_setting,
  input  logic [3:0] min_low_setting,
  output logic       match
);

  // Pure combinational equality of hh:mm plus seconds at zero.
  always_comb begin
    match = (hr_high  == hr_high_setting)  &&
            (hr_low   == hr_low_setting)   &&
            (min_high == min_high_setting) &&
            (min_low  == min_low_setting)  &&
            (sec_high == 4'd0)             &&
            (sec_low  == 4'd0);
  end

endmodule

// File: rtl/alarm_trigger.sv
// Alarm sequencer: detects the rising edge of a time/setting match and
// runs the IDLE / RING / SNOOZE cycle with timed bursts, a bounded number
// of snoozes and a 1 Hz on/off beep pattern. All outputs are registered.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECONDS   = RING_SECONDS_DEFAULT,
  parameter int unsigned SNOOZE_SECONDS = SNOOZE_SECONDS_DEFAULT,
  parameter int unsigned MAX_SNOOZE     = MAX_SNOOZE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       mode,
  input  logic       alarm_en,
  input  logic       stop,
  input  logic       snooze,
  input  logic [3:0] hr_high,
  input  logic [3:0] hr_low,
  input  logic [3:0] min_high,
  input  logic [3:0] min_low,
  input  logic [3:0] sec_high,
  input  logic [3:0] sec_low,
  input  logic [3:0] hr_high_setting,
  input  logic [3:0] hr_low_setting,
  input  logic [3:0] min_high_setting,
  input  logic [3:0] min_low_setting,
  output logic       buzzer,
  output logic       alarm_active,
  output logic       snooze_active,
  output logic [1:0] snooze_left
);

  localparam int unsigned RING_W = $clog2(RING_SECONDS + 1);
  localparam int unsigned SNZ_W  = $clog2(SNOOZE_SECONDS + 1);

  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECONDS);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SECONDS);
  localparam logic [1:0]        LEFT_LOAD = 2'(MAX_SNOOZE);

  state_t            state, state_n;
  logic [RING_W-1:0] ring_cnt, ring_cnt_n;
  logic [SNZ_W-1:0]  snz_cnt, snz_cnt_n;
  logic [1:0]        snooze_left_n;
  logic              beep_phase, beep_phase_n;

  logic time_match;
  logic match;
  logic match_q;
  logic trigger;

  alarm_time_match u_time_match (
    .hr_high          (hr_high),
    .hr_low           (hr_low),
    .min_high         (min_high),
    .min_low          (min_low),
    .sec_high         (sec_high),
    .sec_low          (sec_low),
    .hr_high_setting  (hr_high_setting),
    .hr_low_setting   (hr_low_setting),
    .min_high_setting (min_high_setting),
    .min_low_setting  (min_low_setting),
    .match            (time_match)
  );

  // Qualify the time match and reduce it to a single-cycle rising edge.
  always_comb begin
    match   = mode && alarm_en && time_match;
    trigger = match && !match_q;
  end

  // Next-state logic; branch order encodes event priority:
  // disarm, stop, timeout/expiry, snooze, then plain tick countdown.
  always_comb begin
    state_n       = state;
    ring_cnt_n    = ring_cnt;
    snz_cnt_n     = snz_cnt;
    snooze_left_n = snooze_left;
    beep_phase_n  = beep_phase;

    if (!alarm_en) begin
      state_n       = IDLE;
      snooze_left_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state_n       = RING;
            ring_cnt_n    = RING_LOAD;
            snooze_left_n = LEFT_LOAD;
            beep_phase_n  = 1'b1;
          end
        end

        RING: begin
          if (stop) begin
            state_n       = IDLE;
            snooze_left_n = '0;
          end else if (sec_tick && (ring_cnt == RING_W'(1))) begin
            state_n    = IDLE;
            ring_cnt_n = '0;
          end else if (snooze && (snooze_left != '0)) begin
            state_n       = SNOOZE;
            snz_cnt_n     = SNZ_LOAD;
            snooze_left_n = snooze_left - 2'd1;
          end else if (sec_tick) begin
            if (ring_cnt != '0) begin
              ring_cnt_n = ring_cnt - RING_W'(1);
            end
            beep_phase_n = ~beep_phase;
          end
        end

        SNOOZE: begin
          if (stop) begin
            state_n       = IDLE;
            snooze_left_n = '0;
          end else if (sec_tick && (snz_cnt == SNZ_W'(1))) begin
            state_n      = RING;
            snz_cnt_n    = '0;
            ring_cnt_n   = RING_LOAD;
            beep_phase_n = 1'b1;
          end else if (sec_tick) begin
            if (snz_cnt != '0) begin
              snz_cnt_n = snz_cnt - SNZ_W'(1);
            end
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs; outputs are derived from the
  // next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ring_cnt      <= '0;
      snz_cnt       <= '0;
      snooze_left   <= '0;
      beep_phase    <= 1'b0;
      match_q       <= 1'b1;
      buzzer        <= 1'b0;
      alarm_active  <= 1'b0;
      snooze_active <= 1'b0;
    end else begin
      state         <= state_n;
      ring_cnt      <= ring_cnt_n;
      snz_cnt       <= snz_cnt_n;
      snooze_left   <= snooze_left_n;
      beep_phase    <= beep_phase_n;
      match_q       <= match;
      buzzer        <= (state_n == RING) && beep_phase_n;
      alarm_active  <= (state_n == RING);
      snooze_active <= (state_n == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_trigger.sv
// Scoreboard bench for alarm_trigger: the stimulus process queues the
// expected outputs from an elapsed-seconds reference model, and a monitor
// on the falling edge pops and compares them against the DUT.
module tb_alarm_trigger;

  localparam int RS = 60;
  localparam int SS = 300;
  localparam int MS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_tick = 1'b0;
  logic       mode = 1'b1;
  logic       alarm_en = 1'b1;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic [3:0] hr_high = 4'd0, hr_low = 4'd0, min_high = 4'd0, min_low = 4'd0;
  logic [3:0] sec_high = 4'd0, sec_low = 4'd0;
  logic [3:0] hr_high_setting = 4'd0, hr_low_setting = 4'd7;
  logic [3:0] min_high_setting = 4'd3, min_low_setting = 4'd0;
  logic       buzzer, alarm_active, snooze_active;
  logic [1:0] snooze_left;

  alarm_trigger #(
    .RING_SECONDS   (RS),
    .SNOOZE_SECONDS (SS),
    .MAX_SNOOZE     (MS)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sec_tick         (sec_tick),
    .mode             (mode),
    .alarm_en         (alarm_en),
    .stop             (stop),
    .snooze           (snooze),
    .hr_high          (hr_high),
    .hr_low           (hr_low),
    .min_high         (min_high),
    .min_low          (min_low),
    .sec_high         (sec_high),
    .sec_low          (sec_low),
    .hr_high_setting  (hr_high_setting),
    .hr_low_setting   (hr_low_setting),
    .min_high_setting (min_high_setting),
    .min_low_setting  (min_low_setting),
    .buzzer           (buzzer),
    .alarm_active     (alarm_active),
    .snooze_active    (snooze_active),
    .snooze_left      (snooze_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       buzzer;
    logic       alarm_active;
    logic       snooze_active;
    logic [1:0] snooze_left;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cycle = 0;

  // Reference model: tracks seconds elapsed in the current burst/snooze
  // rather than countdowns, and whether the alarm is ringing or snoozing.
  bit m_ringing = 0;
  bit m_snoozing = 0;
  int m_ring_elapsed = 0;
  int m_snz_elapsed = 0;
  int m_left = 0;
  bit m_prev_match = 1;

  function automatic void model_step();
    bit now_match, trig;
    now_match = mode && alarm_en &&
                ({hr_high, hr_low, min_high, min_low} ==
                 {hr_high_setting, hr_low_setting, min_high_setting, min_low_setting}) &&
                (sec_high == 4'd0) && (sec_low == 4'd0);
    trig = now_match && !m_prev_match;
    m_prev_match = now_match;
    if (!rst_n) begin
      m_ringing = 0; m_snoozing = 0; m_left = 0; m_prev_match = 1;
      m_ring_elapsed = 0; m_snz_elapsed = 0;
    end else if (!alarm_en) begin
      m_ringing = 0; m_snoozing = 0; m_left = 0;
    end else if (m_ringing) begin
      if (stop) begin
        m_ringing = 0; m_left = 0;
      end else if (sec_tick && (m_ring_elapsed + 1 == RS)) begin
        m_ringing = 0;
      end else if (snooze && m_left > 0) begin
        m_ringing = 0; m_snoozing = 1; m_snz_elapsed = 0; m_left--;
      end else if (sec_tick) begin
        m_ring_elapsed++;
      end
    end else if (m_snoozing) begin
      if (stop) begin
        m_snoozing = 0; m_left = 0;
      end else if (sec_tick && (m_snz_elapsed + 1 == SS)) begin
        m_snoozing = 0; m_ringing = 1; m_ring_elapsed = 0;
      end else if (sec_tick) begin
        m_snz_elapsed++;
      end
    end else if (trig) begin
      m_ringing = 1; m_ring_elapsed = 0; m_left = MS;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.buzzer        = m_ringing && (m_ring_elapsed % 2 == 0);
    e.alarm_active  = m_ringing;
    e.snooze_active = m_snoozing;
    e.snooze_left   = 2'(m_left);
    return e;
  endfunction

  task automatic set_time(input int h, input int m, input int s);
    hr_high  = 4'(h / 10); hr_low  = 4'(h % 10);
    min_high = 4'(m / 10); min_low = 4'(m % 10);
    sec_high = 4'(s / 10); sec_low = 4'(s % 10);
  endtask

  task automatic step(input bit tick, input bit stp, input bit snz);
    sec_tick = tick; stop = stp; snooze = snz;
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    sec_tick = 1'b0; stop = 1'b0; snooze = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set to compare.
  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t got;
    cycle++;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      got = '{buzzer, alarm_active, snooze_active, snooze_left};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL outputs cycle %0d: got buzzer=%b alarm_active=%b snooze_active=%b snooze_left=%0d, expected buzzer=%b alarm_active=%b snooze_active=%b snooze_left=%0d",
                 cycle, got.buzzer, got.alarm_active, got.snooze_active, got.snooze_left,
                 e.buzzer, e.alarm_active, e.snooze_active, e.snooze_left);
      end
    end
  end

  initial begin
    // Reset with alarm time 07:30 and clock at 07:29:59.
    set_time(7, 29, 59);
    rst_n = 1'b0;
    repeat (3) step(0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0);
    step(1, 0, 0);

    // Basic ring: triggers on 07:30:00, times out on the 60th tick.
    set_time(7, 30, 0);
    step(0, 0, 0);
    ticks(2);
    set_time(7, 30, 1);
    ticks(RS);
    repeat (3) step(0, 0, 0);

    // Snooze cycle: three snoozes, fourth refused, then stop.
    set_time(7, 30, 0);
    step(0, 0, 0);
    ticks(5);
    step(0, 0, 1);
    set_time(7, 30, 1);
    ticks(SS);
    step(0, 0, 1);
    ticks(SS);
    step(0, 0, 1);
    ticks(SS);
    ticks(3);
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 0, 1);
    step(0, 1, 0);
    step(0, 0, 0);

    // Stop and snooze together during RING: stop wins.
    set_time(7, 30, 0);
    step(0, 0, 0);
    step(0, 1, 1);
    step(0, 0, 0);
    set_time(7, 30, 1);
    step(0, 0, 0);

    // No trigger in setting mode or when disarmed.
    mode = 1'b0;
    set_time(7, 30, 0);
    repeat (2) step(0, 0, 0);
    set_time(7, 30, 1);
    mode = 1'b1;
    step(0, 0, 0);
    alarm_en = 1'b0;
    set_time(7, 30, 0);
    repeat (2) step(0, 0, 0);
    set_time(7, 30, 1);
    alarm_en = 1'b1;
    step(0, 0, 0);

    // Disarm while snoozing.
    set_time(7, 30, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    ticks(3);
    alarm_en = 1'b0;
    step(0, 0, 0);
    set_time(7, 30, 1);
    alarm_en = 1'b1;
    step(0, 0, 0);

    // Reset release during the matching second, then next-day trigger,
    // then reset mid-ring.
    set_time(7, 30, 0);
    rst_n = 1'b0;
    repeat (2) step(0, 0, 0);
    rst_n = 1'b1;
    repeat (3) step(0, 0, 0);
    set_time(7, 30, 1);
    step(0, 0, 0);
    set_time(7, 30, 0);
    step(0, 0, 0);
    ticks(4);
    rst_n = 1'b0;
    step(0, 0, 0);
    rst_n = 1'b1;
    repeat (2) step(0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: set_time(7, 30, 0);
          1: set_time(7, 30, 1);
          2: set_time(7, 29, 59);
          default: set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
        endcase
      end
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      alarm_en = ($urandom_range(0, 59) != 0);
      rst_n    = ($urandom_range(0, 399) != 0);
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
